fractal_pixel_scheduler: RTL
============================

Name: fractal_pixel_scheduler

Overview:
- Sequences a frame of escape-time fractal pixels across NUM_ENGINES identical iteration engines.
- Walks raster order and dispatches (x, y, mode) to engines round-robin.
- Retires results in the same round-robin order, so output stays raster-ordered with no reorder buffer.
- Sits between the AXI-Lite register file (start/mode/abort) and the colour-map/pixel packer stream.

Parameters:
- NUM_ENGINES, 4, number of iteration engines (power of two, 1..16)
- X_SIZE, 640, pixels per line
- Y_SIZE, 480, lines per frame
- ITER_W, 8, width of an engine's iteration-count result

Ports:
- aclk  in  1  sole clock
- areset  in  1  asynchronous, active-high reset
- frame_start  in  1  pulse: begin a frame (ignored unless IDLE)
- mode_in  in  1  0 = Mandelbrot, 1 = Julia; sampled on accepted frame_start
- abort  in  1  level: cancel current frame
- busy  out  1  high in RUN or FLUSH
- eng_start  out  NUM_ENGINES  one-hot start pulse to an engine
- eng_x  out  16  pixel x for the started engine
- eng_y  out  16  pixel y for the started engine
- eng_mode  out  1  latched mode
- eng_idle  in  NUM_ENGINES  engine can accept a start
- eng_done  in  NUM_ENGINES  engine holds a result (level, until acked)
- eng_iter  in  NUM_ENGINES*ITER_W  per-engine results, engine i at [i*ITER_W +: ITER_W]
- eng_ack  out  NUM_ENGINES  one-hot, one-cycle: result consumed, engine returns to idle
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_iter  out  ITER_W  iteration count of current pixel
- out_sof  out  1  first pixel of frame
- out_eol  out  1  last pixel of line
- out_eof  out  1  last pixel of frame
- frame_cycles  out  32  see Optional Feature

Behaviour:
- Reset (async, areset=1):
  - State returns to IDLE.
  - All outputs are 0.
  - Pointers and counters are cleared.
  - Engines share areset.
- States:
  - IDLE: frame_start=1 -> RUN. Latch mode_in. Clear dispatch position (dx, dy) and retire position (rx, ry). Clear d_ptr, r_ptr and outstanding.
  - RUN: dispatch and retire as below.
    - Last pixel retired -> IDLE.
    - abort=1 -> FLUSH; takes priority over completion in the same cycle.
  - FLUSH:
    - No dispatch; out_valid held 0.
    - Each cycle eng_done[r_ptr]=1: pulse eng_ack[r_ptr], advance r_ptr, decrement outstanding.
    - outstanding==0 -> IDLE.
- Dispatch (RUN only), when pixels remain, outstanding < NUM_ENGINES and eng_idle[d_ptr]=1:
  - Pulse eng_start[d_ptr] with eng_x=dx, eng_y=dy in the same cycle (registered outputs).
  - Advance d_ptr mod NUM_ENGINES.
  - Advance dx; wrap at X_SIZE-1 to 0 with dy++.
  - Increment outstanding.
  - At most one dispatch per cycle.
- Retire (RUN):
  - out_valid = eng_done[r_ptr]; out_iter = eng_iter slice r_ptr.
  - out_sof = (rx==0 && ry==0); out_eol = (rx==X_SIZE-1); out_eof = out_eol && ry==Y_SIZE-1.
  - On out_valid && out_ready: eng_ack[r_ptr] pulses combinationally that cycle; r_ptr, rx/ry advance; outstanding--.
  - out_valid/out_iter/flags hold stable while out_ready=0.
- Simultaneous dispatch and retire: outstanding unchanged; both pointers advance.
- eng_done on an engine other than r_ptr is ignored until r_ptr reaches it.
- Engine latency is arbitrary; minimum engine-to-output latency is 0 cycles after eng_done.
- Throughput: at most one pixel out per cycle.
- frame_start during RUN/FLUSH: ignored. abort in IDLE: no effect.
- Counter widths: x/y counters 16 bits; outstanding is clog2(NUM_ENGINES)+1 bits.

Optional Feature:
- Macro SCHED_PERF_CNT_EN.
- Defined:
  - 32-bit counter clears on RUN entry and increments every cycle in RUN.
  - On the transition into IDLE after the eof handshake, it is copied to frame_cycles.
  - Aborted frames leave frame_cycles unchanged.
  - The counter saturates at 0xFFFFFFFF.
- Undefined: frame_cycles tied to 0; no counter logic.

Test Plan:
- NUM_ENGINES=2, X_SIZE=4, Y_SIZE=2; engines finish in 3 cycles with iter=x+4y; out_ready=1 -> out_iter sequence 0..7; sof on 1st pixel only; eol on 4th and 8th; eof on 8th; then IDLE, busy=0.
- Same config, engine 1 latency 10, engine 0 latency 1 -> output remains raster order 0..7; outstanding never exceeds 2; no eng_start to a non-idle engine.
- out_ready held 0 for 5 cycles at pixel 3 -> out_valid stays 1, out_iter=3 stable; no eng_ack; dispatch stalls once both engines are done.
- abort asserted after 3 pixels retired, 2 outstanding -> no further out_valid; both engines acked in FLUSH; IDLE once outstanding reaches 0; new frame_start then yields a clean sof at pixel 0.
- areset pulsed mid-frame (asynchronous, between clock edges) -> all outputs 0 immediately; frame_start with mode_in=1 -> eng_mode=1 on all starts.
- SCHED_PERF_CNT_EN defined, engine latency 1, out_ready=1, 8-pixel frame -> frame_cycles equals the measured RUN-cycle count; aborted frame leaves it unchanged.

Source files
------------

// File: rtl/fractal_pixel_scheduler.sv
// Raster-order pixel dispatcher/retirer for NUM_ENGINES round-robin iteration engines.
// Optional frame cycle counter enabled by defining SCHED_PERF_CNT_EN.
module fractal_pixel_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int X_SIZE      = 640,
    parameter int Y_SIZE      = 480,
    parameter int ITER_W      = 8
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          frame_start,
    input  logic                          mode_in,
    input  logic                          abort,
    output logic                          busy,
    output logic [NUM_ENGINES-1:0]        eng_start,
    output logic [15:0]                   eng_x,
    output logic [15:0]                   eng_y,
    output logic                          eng_mode,
    input  logic [NUM_ENGINES-1:0]        eng_idle,
    input  logic [NUM_ENGINES-1:0]        eng_done,
    input  logic [NUM_ENGINES*ITER_W-1:0] eng_iter,
    output logic [NUM_ENGINES-1:0]        eng_ack,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ITER_W-1:0]             out_iter,
    output logic                          out_sof,
    output logic                          out_eol,
    output logic                          out_eof,
    output logic [31:0]                   frame_cycles
);
    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int OUT_W = $clog2(NUM_ENGINES) + 1;
    localparam logic [15:0]      X_LAST   = 16'(X_SIZE - 1);
    localparam logic [15:0]      Y_LAST   = 16'(Y_SIZE - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_ENGINES - 1);
    localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(NUM_ENGINES);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [15:0]      dx_q, dx_d, dy_q, dy_d, rx_q, rx_d, ry_q, ry_d;
    logic [PTR_W-1:0] d_ptr_q, d_ptr_d, r_ptr_q, r_ptr_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic             d_done_q, d_done_d, mode_q, mode_d;
    logic             dispatch, retire, flush_ack, last_pix, run_ok;
    logic [ITER_W-1:0] cur_iter;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        cur_iter  = eng_iter[r_ptr_q*ITER_W +: ITER_W];
        // abort wins over both dispatch and retirement in its first cycle
        run_ok    = (state_q == ST_RUN) && !abort;
        dispatch  = run_ok && !d_done_q && (outst_q < OUT_MAX) && eng_idle[d_ptr_q];
        out_valid = run_ok && eng_done[r_ptr_q];
        retire    = out_valid && out_ready;
        flush_ack = (state_q == ST_FLUSH) && (outst_q != '0) && eng_done[r_ptr_q];
        last_pix  = (rx_q == X_LAST) && (ry_q == Y_LAST);
        eng_start = dispatch ? (NUM_ENGINES'(1) << d_ptr_q) : '0;
        eng_ack   = (retire || flush_ack) ? (NUM_ENGINES'(1) << r_ptr_q) : '0;
        out_iter  = out_valid ? cur_iter : '0;
        out_sof   = out_valid && (rx_q == 16'd0) && (ry_q == 16'd0);
        out_eol   = out_valid && (rx_q == X_LAST);
        out_eof   = out_valid && last_pix;
        busy      = (state_q != ST_IDLE);
        eng_x     = dx_q;
        eng_y     = dy_q;
        eng_mode  = mode_q;

        state_d  = state_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        rx_d     = rx_q;
        ry_d     = ry_q;
        d_ptr_d  = d_ptr_q;
        r_ptr_d  = r_ptr_q;
        outst_d  = outst_q;
        d_done_d = d_done_q;
        mode_d   = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d  = ST_RUN;
                    mode_d   = mode_in;
                    dx_d     = '0;
                    dy_d     = '0;
                    rx_d     = '0;
                    ry_d     = '0;
                    d_ptr_d  = '0;
                    r_ptr_d  = '0;
                    outst_d  = '0;
                    d_done_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (dispatch) begin
                    d_ptr_d = next_ptr(d_ptr_q);
                    if (dx_q == X_LAST) begin
                        dx_d = '0;
                        dy_d = dy_q + 16'd1;
                        if (dy_q == Y_LAST) d_done_d = 1'b1;
                    end else begin
                        dx_d = dx_q + 16'd1;
                    end
                end
                if (retire) begin
                    r_ptr_d = next_ptr(r_ptr_q);
                    if (rx_q == X_LAST) begin
                        rx_d = '0;
                        ry_d = ry_q + 16'd1;
                    end else begin
                        rx_d = rx_q + 16'd1;
                    end
                end
                if (dispatch && !retire)      outst_d = outst_q + 1'b1;
                else if (!dispatch && retire) outst_d = outst_q - 1'b1;
                if (abort)                    state_d = ST_FLUSH;
                else if (retire && last_pix)  state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                if (flush_ack) begin
                    r_ptr_d = next_ptr(r_ptr_q);
                    outst_d = outst_q - 1'b1;
                end
                if (outst_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            dx_q     <= '0;
            dy_q     <= '0;
            rx_q     <= '0;
            ry_q     <= '0;
            d_ptr_q  <= '0;
            r_ptr_q  <= '0;
            outst_q  <= '0;
            d_done_q <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            rx_q     <= rx_d;
            ry_q     <= ry_d;
            d_ptr_q  <= d_ptr_d;
            r_ptr_q  <= r_ptr_d;
            outst_q  <= outst_d;
            d_done_q <= d_done_d;
            mode_q   <= mode_d;
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] cyc_q, cyc_d, fc_q, fc_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // the final RUN cycle is included in the published count
    always_comb begin
        cyc_d = cyc_q;
        fc_d  = fc_q;
        if ((state_q == ST_IDLE) && frame_start) cyc_d = '0;
        else if (state_q == ST_RUN)              cyc_d = sat_inc(cyc_q);
        if ((state_q == ST_RUN) && !abort && retire && last_pix) fc_d = sat_inc(cyc_q);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cyc_q <= '0;
            fc_q  <= '0;
        end else begin
            cyc_q <= cyc_d;
            fc_q  <= fc_d;
        end
    end

    assign frame_cycles = fc_q;
`else
    assign frame_cycles = '0;
`endif
endmodule
